// File: rtl/memarb_pkg.sv
// Shared types and constants for the external-memory arbiter.
// Client indices also set the round-robin order.
package memarb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [1:0] CL_PROM   = 2'd0;
    localparam logic [1:0] CL_CROM   = 2'd1;
    localparam logic [1:0] CL_CHRRAM = 2'd2;
    localparam logic [1:0] CL_PRGRAM = 2'd3;

    localparam logic [22:0] DEF_PROMBASE   = 23'h000000;
    localparam logic [22:0] DEF_CROMBASE   = 23'h200000;
    localparam logic [22:0] DEF_PRGRAMBASE = 23'h400000;
    localparam logic [22:0] DEF_CHRRAMBASE = 23'h408000;

    function automatic logic is_rom(input logic [1:0] c);
        return (c == CL_PROM) || (c == CL_CROM);
    endfunction

endpackage

// File: rtl/memarb_if.sv
// External 8-bit memory port: request side from the arbiter,
// completion side from the memory.
interface memarb_if;

    logic [22:0] extaddr;
    logic [7:0]  extwdata;
    logic        extwr;
    logic        extreq;
    logic [7:0]  extrdata;
    logic        extack;

    modport master (
        output extaddr,
        output extwdata,
        output extwr,
        output extreq,
        input  extrdata,
        input  extack
    );

    modport slave (
        input  extaddr,
        input  extwdata,
        input  extwr,
        input  extreq,
        output extrdata,
        output extack
    );

endinterface

// File: rtl/memarb_rrarb.sv
// 4-way combinational round-robin picker; the search starts
// just after the last granted index.
module rrarb (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       gv,
    output logic [1:0] gidx
);

    // Walk from farthest to nearest so the nearest requester wins.
    always_comb begin
        gv   = 1'b0;
        gidx = last;
        for (int i = 4; i >= 1; i--) begin
            if (req[last + 2'(i)]) begin
                gv   = 1'b1;
                gidx = last + 2'(i);
            end
        end
    end

endmodule

// File: rtl/memarb.sv
// Serialises the four mapper memory channels onto one external
// port with round-robin grant, bounded wait and sticky errors.
module memarb
    import memarb_pkg::*;
#(
    parameter int          TIMEOUT    = 255,
    parameter logic [22:0] PROMBASE   = DEF_PROMBASE,
    parameter logic [22:0] CROMBASE   = DEF_CROMBASE,
    parameter logic [22:0] PRGRAMBASE = DEF_PRGRAMBASE,
    parameter logic [22:0] CHRRAMBASE = DEF_CHRRAMBASE
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic [20:0] promaddr,
    input  logic        promreq,
    output logic [7:0]  promdata,
    output logic        promack,

    input  logic [20:0] cromaddr,
    input  logic        cromreq,
    output logic [7:0]  cromdata,
    output logic        cromack,

    input  logic [12:0] chrramaddr,
    input  logic [7:0]  chrramwdata,
    input  logic        chrramwr,
    input  logic        chrramreq,
    output logic [7:0]  chrramrdata,
    output logic        chrramack,

    input  logic [14:0] prgramaddr,
    input  logic [7:0]  prgramwdata,
    input  logic        prgramwr,
    input  logic        prgramreq,
    output logic [7:0]  prgramrdata,
    output logic        prgramack,

    memarb_if.master    ext,

    output logic [1:0]  err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state, state_n;
    logic [3:0]      req;
    logic [3:0]      cwr;
    logic            gv;
    logic [1:0]      gidx;
    logic [1:0]      idx;
    logic [1:0]      last;
    logic [CW-1:0]   cnt;
    logic            tmo;
    logic            grant;
    logic            fin;

    logic [22:0]     gaddr;
    logic [7:0]      gwd;
    logic            gwr;

    logic [22:0]     addr_q;
    logic [7:0]      wdata_q;
    logic            wr_q;
    logic            xreq_q;
    logic [3:0]      ack_q;
    logic [3:0][7:0] dat;

    assign req = {prgramreq, chrramreq, cromreq, promreq};
    // ROM channels have no write strobe; a future one is trapped below.
    assign cwr = {prgramwr, chrramwr, 1'b0, 1'b0};

    rrarb u_rr (
        .req  (req),
        .last (last),
        .gv   (gv),
        .gidx (gidx)
    );

    always_comb begin
        gaddr = '0;
        gwd   = '0;
        unique case (gidx)
            CL_PROM:   gaddr = PROMBASE + {2'b0, promaddr};
            CL_CROM:   gaddr = CROMBASE + {2'b0, cromaddr};
            CL_CHRRAM: begin
                gaddr = CHRRAMBASE + {10'b0, chrramaddr};
                gwd   = chrramwdata;
            end
            CL_PRGRAM: begin
                gaddr = PRGRAMBASE + {8'b0, prgramaddr};
                gwd   = prgramwdata;
            end
        endcase
    end

    assign gwr   = cwr[gidx] & ~is_rom(gidx);
    assign tmo   = (cnt == CW'(TIMEOUT));
    assign grant = (state == S_IDLE) && gv;
    assign fin   = (state == S_BUSY) && (ext.extack || tmo);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (gv) state_n = S_BUSY;
            S_BUSY:  if (ext.extack || tmo) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx     <= CL_PROM;
            last    <= CL_PRGRAM;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            xreq_q  <= 1'b0;
            ack_q   <= '0;
            dat     <= '0;
            err     <= '0;
        end else begin
            ack_q <= '0;
            if (grant) begin
                idx     <= gidx;
                addr_q  <= gaddr;
                wdata_q <= gwd;
                wr_q    <= gwr;
                xreq_q  <= 1'b1;
                cnt     <= '0;
                if (cwr[gidx] && is_rom(gidx)) err[1] <= 1'b1;
            end
            if (state == S_BUSY) begin
                // A coinciding ack beats the timeout.
                if (fin) begin
                    dat[idx]   <= ext.extack ? ext.extrdata : 8'hFF;
                    xreq_q     <= 1'b0;
                    ack_q[idx] <= 1'b1;
                    if (!ext.extack) err[0] <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (state == S_DONE) last <= idx;
        end
    end

    assign ext.extaddr  = addr_q;
    assign ext.extwdata = wdata_q;
    assign ext.extwr    = wr_q;
    assign ext.extreq   = xreq_q;

    assign promack     = ack_q[CL_PROM];
    assign cromack     = ack_q[CL_CROM];
    assign chrramack   = ack_q[CL_CHRRAM];
    assign prgramack   = ack_q[CL_PRGRAM];
    assign promdata    = dat[CL_PROM];
    assign cromdata    = dat[CL_CROM];
    assign chrramrdata = dat[CL_CHRRAM];
    assign prgramrdata = dat[CL_PRGRAM];

endmodule

// File: tb/tb_memarb.sv
// Directed bench for memarb with a short wait bound so the
// timeout and ack-on-timeout corners are reachable.
module tb_memarb;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [20:0] promaddr = '0;
    logic        promreq = 1'b0;
    logic [7:0]  promdata;
    logic        promack;
    logic [20:0] cromaddr = '0;
    logic        cromreq = 1'b0;
    logic [7:0]  cromdata;
    logic        cromack;
    logic [12:0] chrramaddr = '0;
    logic [7:0]  chrramwdata = '0;
    logic        chrramwr = 1'b0;
    logic        chrramreq = 1'b0;
    logic [7:0]  chrramrdata;
    logic        chrramack;
    logic [14:0] prgramaddr = '0;
    logic [7:0]  prgramwdata = '0;
    logic        prgramwr = 1'b0;
    logic        prgramreq = 1'b0;
    logic [7:0]  prgramrdata;
    logic        prgramack;
    logic [1:0]  err;

    memarb_if ext();

    memarb #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .promaddr    (promaddr),
        .promreq     (promreq),
        .promdata    (promdata),
        .promack     (promack),
        .cromaddr    (cromaddr),
        .cromreq     (cromreq),
        .cromdata    (cromdata),
        .cromack     (cromack),
        .chrramaddr  (chrramaddr),
        .chrramwdata (chrramwdata),
        .chrramwr    (chrramwr),
        .chrramreq   (chrramreq),
        .chrramrdata (chrramrdata),
        .chrramack   (chrramack),
        .prgramaddr  (prgramaddr),
        .prgramwdata (prgramwdata),
        .prgramwr    (prgramwr),
        .prgramreq   (prgramreq),
        .prgramrdata (prgramrdata),
        .prgramack   (prgramack),
        .ext         (ext),
        .err         (err)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    int n;
    int ackcnt[4];
    logic [3:0]      acks;
    logic [3:0][7:0] cdat;
    logic [22:0]     xaddr[4];

    assign acks = {prgramack, chrramack, cromack, promack};
    assign cdat = {prgramrdata, chrramrdata, cromdata, promdata};

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) ackcnt[i] += int'(acks[i]);
    endtask

    task automatic clrcnt();
        for (int i = 0; i < 4; i++) ackcnt[i] = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        ext.extack   = 1'b0;
        ext.extrdata = '0;
        clrcnt();

        // Reset values
        tick();
        tick();
        chk("rst_extreq", 32'(ext.extreq), 32'd0);
        chk("rst_acks", 32'(acks), 32'd0);
        chk("rst_extaddr", 32'(ext.extaddr), 32'd0);
        chk("rst_extwdata", 32'(ext.extwdata), 32'd0);
        chk("rst_extwr", 32'(ext.extwr), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cdat", 32'(cdat), 32'd0);
        resetn = 1'b1;
        tick();

        // Single prom read, extack one cycle after extreq
        promaddr = 21'h001234;
        promreq  = 1'b1;
        tick();
        chk("p1_extreq", 32'(ext.extreq), 32'd1);
        chk("p1_extaddr", 32'(ext.extaddr), 32'h001234);
        chk("p1_extwr", 32'(ext.extwr), 32'd0);
        chk("p1_noack_c1", 32'(acks), 32'd0);
        tick();
        chk("p1_noack_c2", 32'(acks), 32'd0);
        ext.extrdata = 8'hA5;
        ext.extack   = 1'b1;
        tick();
        ext.extack = 1'b0;
        chk("p1_ack_c3", 32'(acks), 32'b0001);
        chk("p1_data", 32'(promdata), 32'hA5);
        chk("p1_extreq_drop", 32'(ext.extreq), 32'd0);
        tick();
        promreq = 1'b0;
        chk("p1_single_ack", 32'(acks), 32'd0);

        // Stray extack while idle is ignored
        ext.extrdata = 8'h99;
        ext.extack   = 1'b1;
        tick();
        ext.extack = 1'b0;
        tick();
        chk("stray_acks", 32'(acks), 32'd0);
        chk("stray_data", 32'(promdata), 32'hA5);
        chk("stray_extreq", 32'(ext.extreq), 32'd0);

        // chrram write at top of window
        chrramaddr  = 13'h1FFF;
        chrramwdata = 8'h3C;
        chrramwr    = 1'b1;
        chrramreq   = 1'b1;
        tick();
        chk("cw_extaddr", 32'(ext.extaddr), 32'h409FFF);
        chk("cw_extwr", 32'(ext.extwr), 32'd1);
        chk("cw_extwdata", 32'(ext.extwdata), 32'h3C);
        ext.extrdata = 8'h00;
        ext.extack   = 1'b1;
        tick();
        ext.extack = 1'b0;
        chk("cw_ack", 32'(acks), 32'b0100);
        tick();
        chrramreq = 1'b0;
        chrramwr  = 1'b0;
        chk("cw_single_ack", 32'(acks), 32'd0);

        // prgram read at top of window
        prgramaddr = 15'h7FFF;
        prgramreq  = 1'b1;
        tick();
        chk("pr_extaddr", 32'(ext.extaddr), 32'h407FFF);
        chk("pr_extwr", 32'(ext.extwr), 32'd0);
        ext.extrdata = 8'h5A;
        ext.extack   = 1'b1;
        tick();
        ext.extack = 1'b0;
        chk("pr_ack", 32'(acks), 32'b1000);
        chk("pr_data", 32'(prgramrdata), 32'h5A);
        tick();
        prgramreq = 1'b0;

        // All four requesting: strict rotation from prom
        xaddr[0]   = 23'h1FFFFF;
        xaddr[1]   = 23'h200010;
        xaddr[2]   = 23'h408001;
        xaddr[3]   = 23'h400002;
        promaddr   = 21'h1FFFFF;
        cromaddr   = 21'h000010;
        chrramaddr = 13'h0001;
        prgramaddr = 15'h0002;
        promreq    = 1'b1;
        cromreq    = 1'b1;
        chrramreq  = 1'b1;
        prgramreq  = 1'b1;
        clrcnt();
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (!ext.extreq && n < 8) begin
                tick();
                n++;
            end
            chk($sformatf("rr%0d_extreq", k), 32'(ext.extreq), 32'd1);
            chk($sformatf("rr%0d_extaddr", k), 32'(ext.extaddr),
                32'(xaddr[k % 4]));
            ext.extrdata = 8'(8'h40 + k);
            ext.extack   = 1'b1;
            tick();
            ext.extack = 1'b0;
            chk($sformatf("rr%0d_ack", k), 32'(acks),
                32'd1 << (k % 4));
            chk($sformatf("rr%0d_data", k), 32'(cdat[k % 4]),
                32'(8'h40 + k));
        end
        tick();
        promreq   = 1'b0;
        cromreq   = 1'b0;
        chrramreq = 1'b0;
        prgramreq = 1'b0;
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_count%0d", i), 32'(ackcnt[i]), 32'd2);

        // crom: extack on the exact timeout cycle wins
        cromaddr = 21'h1FFFFF;
        cromreq  = 1'b1;
        tick();
        chk("ct_extaddr", 32'(ext.extaddr), 32'h3FFFFF);
        tick();
        tick();
        tick();
        tick();
        chk("ct_extreq_last", 32'(ext.extreq), 32'd1);
        chk("ct_noack", 32'(acks), 32'd0);
        ext.extrdata = 8'h11;
        ext.extack   = 1'b1;
        tick();
        ext.extack = 1'b0;
        chk("ct_ack", 32'(acks), 32'b0010);
        chk("ct_data", 32'(cromdata), 32'h11);
        chk("ct_err", 32'(err), 32'd0);
        tick();
        cromreq = 1'b0;

        // prom with no extack: forced completion
        promaddr = 21'h000100;
        promreq  = 1'b1;
        tick();
        chk("to_extaddr", 32'(ext.extaddr), 32'h000100);
        n = 0;
        while (ext.extreq && n < 20) begin
            n++;
            tick();
        end
        chk("to_extreq_cycles", 32'(n), 32'd5);
        chk("to_ack", 32'(acks), 32'b0001);
        chk("to_data", 32'(promdata), 32'hFF);
        chk("to_err", 32'(err), 32'b01);
        tick();
        promreq = 1'b0;

        // Sticky error survives a good transaction
        chrramaddr = 13'h0000;
        chrramreq  = 1'b1;
        tick();
        chk("ok_extaddr", 32'(ext.extaddr), 32'h408000);
        ext.extrdata = 8'h77;
        ext.extack   = 1'b1;
        tick();
        ext.extack = 1'b0;
        chk("ok_ack", 32'(acks), 32'b0100);
        chk("ok_data", 32'(chrramrdata), 32'h77);
        chk("ok_err_sticky", 32'(err), 32'b01);
        tick();
        chrramreq = 1'b0;

        // Reset while BUSY
        prgramaddr = 15'h0010;
        prgramreq  = 1'b1;
        tick();
        chk("rb_extreq", 32'(ext.extreq), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rb_extreq_clr", 32'(ext.extreq), 32'd0);
        chk("rb_acks_clr", 32'(acks), 32'd0);
        chk("rb_err_clr", 32'(err), 32'd0);
        prgramreq = 1'b0;
        clrcnt();
        tick();
        tick();
        resetn = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("rb_no_ack",
            32'(ackcnt[0] + ackcnt[1] + ackcnt[2] + ackcnt[3]), 32'd0);
        chk("rb_idle", 32'(ext.extreq), 32'd0);

        promaddr = 21'h000055;
        cromaddr = 21'h000000;
        promreq  = 1'b1;
        cromreq  = 1'b1;
        tick();
        chk("rb_first_addr", 32'(ext.extaddr), 32'h000055);
        ext.extrdata = 8'hC3;
        ext.extack   = 1'b1;
        tick();
        ext.extack = 1'b0;
        chk("rb_first_ack", 32'(acks), 32'b0001);
        chk("rb_first_data", 32'(promdata), 32'hC3);
        tick();
        promreq = 1'b0;
        n = 0;
        while (!ext.extreq && n < 8) begin
            tick();
            n++;
        end
        chk("rb_second_addr", 32'(ext.extaddr), 32'h200000);
        ext.extrdata = 8'h3E;
        ext.extack   = 1'b1;
        tick();
        ext.extack = 1'b0;
        chk("rb_second_ack", 32'(acks), 32'b0010);
        chk("rb_second_data", 32'(cromdata), 32'h3E);
        tick();
        cromreq = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
